// File: rtl/serial_rx_pkg.sv
// Shared constants and helpers for the multi-lane serial receiver.
package serial_rx_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int cnt_w(input int packet_length);
        return clog2(packet_length + 1);
    endfunction

    // FIFO entry layout is {partial, data}
    function automatic int entry_w(input int packet_length);
        return packet_length + 1;
    endfunction

    localparam int OVF_W = 16;
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

endpackage

// File: rtl/rx_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible on dout while not empty.
module rx_sync_fifo
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop frees the slot the simultaneous push lands in
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/serial_rx_lanes.sv
// Oversampling multi-lane serial receiver: synchronise, assemble words,
// flush short packets and queue them toward a valid/ready consumer.
module serial_rx_lanes
    import serial_rx_pkg::*;
#(
    parameter int PACKET_LENGTH = 32,
    parameter int LANES         = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int MSB_FIRST     = 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     sclk,
    input  logic                     svalid,
    input  logic [LANES-1:0]         sdata,
    output logic [PACKET_LENGTH-1:0] fifo_data,
    output logic                     fifo_partial,
    output logic                     fifo_valid,
    input  logic                     fifo_ready,
    output logic [OVF_W-1:0]         overflow_count,
    output logic                     busy
);
    localparam int CNT_W   = cnt_w(PACKET_LENGTH);
    localparam int ENTRY_W = entry_w(PACKET_LENGTH);

    logic [SYNC_STAGES-1:0]   sclk_sync;
    logic [SYNC_STAGES-1:0]   svalid_sync;
    logic [LANES-1:0]         sdata_sync [SYNC_STAGES];
    logic                     sclk_s, svalid_s, sclk_q, svalid_q;
    logic [LANES-1:0]         sdata_s;
    logic                     sample, flush, word_done;
    logic [CNT_W-1:0]         bit_cnt;
    logic [PACKET_LENGTH-1:0] shreg, shreg_next, beat_word;
    logic                     push_p0;
    logic [ENTRY_W-1:0]       entry_p0;
    logic [ENTRY_W-1:0]       head;
    logic                     full, empty, pop, drop;

    // Stage: synchronisers and edge-detect history
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sclk_sync   <= '0;
            svalid_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sdata_sync[i] <= '0;
            sclk_q      <= 1'b0;
            svalid_q    <= 1'b0;
        end else begin
            sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            svalid_sync   <= {svalid_sync[SYNC_STAGES-2:0], svalid};
            sdata_sync[0] <= sdata;
            for (int i = 1; i < SYNC_STAGES; i++) sdata_sync[i] <= sdata_sync[i-1];
            sclk_q        <= sclk_s;
            svalid_q      <= svalid_s;
        end
    end

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign svalid_s = svalid_sync[SYNC_STAGES-1];
    assign sdata_s  = sdata_sync[SYNC_STAGES-1];

    assign sample    = sclk_s && !sclk_q && svalid_s;
    assign flush     = svalid_q && !svalid_s && (bit_cnt != '0);
    assign word_done = (bit_cnt + CNT_W'(LANES)) == CNT_W'(PACKET_LENGTH);

    always_comb begin
        beat_word              = '0;
        beat_word[LANES-1:0]   = sdata_s;
        if (MSB_FIRST != 0) shreg_next = (shreg << LANES) | beat_word;
        else                shreg_next = shreg | (beat_word << bit_cnt);
    end

    // Stage p0: assembly and push register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bit_cnt <= '0;
            shreg   <= '0;
            push_p0 <= 1'b0;
        end else begin
            push_p0 <= 1'b0;
            if (sample) begin
                if (word_done) begin
                    push_p0 <= 1'b1;
                    bit_cnt <= '0;
                    shreg   <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(LANES);
                    shreg   <= shreg_next;
                end
            end else if (flush) begin
                push_p0 <= 1'b1;
                bit_cnt <= '0;
                shreg   <= '0;
            end
        end
    end

    // Partial words are already right/low aligned with zero upper bits
    always_ff @(posedge aclk) begin
        if (sample && word_done) entry_p0 <= {1'b0, shreg_next};
        else if (flush)          entry_p0 <= {1'b1, shreg};
    end

    // Stage p1: output FIFO and drop accounting
    assign pop  = fifo_valid && fifo_ready;
    assign drop = push_p0 && full && !pop;

    rx_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push_p0),
        .din     (entry_p0),
        .full    (full),
        .pop     (pop),
        .dout    (head),
        .empty   (empty)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                               overflow_count <= '0;
        else if (drop && overflow_count != OVF_MAX) overflow_count <= overflow_count + 1'b1;
    end

    assign fifo_valid   = !empty;
    assign fifo_data    = head[PACKET_LENGTH-1:0];
    assign fifo_partial = head[PACKET_LENGTH];
    assign busy         = (bit_cnt != '0);

endmodule

// File: doc/serial_rx_lanes.md
Name: serial_rx_lanes

Overview:
- Parametrised successor to the single-lane serial receiver.
- Samples an external serial bus (sclk, svalid, LANES-wide sdata) by oversampling it in the single aclk domain.
- Assembles PACKET_LENGTH-bit words and flushes short packets with a partial flag.
- Buffers words in a FIFO_DEPTH-entry show-ahead FIFO toward a valid/ready consumer, and counts dropped words.

Parameters:
- PACKET_LENGTH, 32: bits per word. Must be a multiple of LANES.
- LANES, 1: serial data lanes sampled per sclk edge. Legal values 1, 2, 4, 8.
- FIFO_DEPTH, 4: output FIFO entries. Power of 2, at least 2.
- SYNC_STAGES, 2: synchroniser flops on sclk/svalid/sdata. At least 2.
- MSB_FIRST, 1: 1 = first beat is most significant; 0 = first beat lands in the LSBs.

Ports:
- aclk, input, 1: sole clock. All logic is on the rising edge.
- aresetn, input, 1: reset, asynchronous and active-low.
- sclk, input, 1: external serial clock, asynchronous to aclk. Data is sampled on its rising edge.
- svalid, input, 1: packet framing, asynchronous. High for the duration of a packet.
- sdata, input, LANES: serial data, asynchronous. Bit LANES-1 is most significant within a beat.
- fifo_data, output, PACKET_LENGTH: head-of-FIFO word.
- fifo_partial, output, 1: head word was a flushed short packet.
- fifo_valid, output, 1: FIFO not empty.
- fifo_ready, input, 1: consumer accepts the head word.
- overflow_count, output, 16: words dropped because the FIFO was full. Saturating.
- busy, output, 1: a packet is partially assembled (bit count nonzero).

Behaviour:
- Timing requirement: aclk frequency is at least 4x sclk. sdata and svalid are stable for at least 2 aclk periods around each sclk rising edge.
- Synchronisers:
  - sclk, svalid and every sdata bit pass through SYNC_STAGES flops, giving sclk_s, svalid_s and sdata_s.
  - All synchroniser flops reset to 0.
  - One extra flop each holds sclk_q and svalid_q.
- Events:
  - Sample: sclk_s=1, sclk_q=0 and svalid_s=1.
  - Flush: svalid_q=1, svalid_s=0 and bit_cnt!=0.
  - Sample and flush are mutually exclusive because a sample requires svalid_s=1.
  - A sample with svalid_s=0 is ignored.
- Assembly:
  - The shift register is PACKET_LENGTH bits and bit_cnt runs 0..PACKET_LENGTH.
  - MSB_FIRST=1: shreg <= {shreg[PACKET_LENGTH-LANES-1:0], sdata_s}.
  - MSB_FIRST=0: beat k is written to bits [k*LANES +: LANES].
  - Each sample adds LANES to bit_cnt.
  - When bit_cnt+LANES == PACKET_LENGTH, the assembled word is pushed with partial=0. bit_cnt and shreg clear in the same cycle.
- Flush:
  - Pushes the received bits with partial=1, then clears bit_cnt and shreg.
  - MSB_FIRST=1: the word is right-aligned and zero-extended (upper bits 0).
  - MSB_FIRST=0: the word is low-aligned with zero upper bits.
  - An svalid rise-and-fall with no samples pushes nothing.
- busy = (bit_cnt != 0).
- Latency: from the sclk edge that completes a word to fifo_valid is at most SYNC_STAGES+3 aclk cycles (synchroniser, edge detect, push register, FIFO output).
- FIFO:
  - Show-ahead. fifo_valid = !empty, and fifo_data/fifo_partial show the head entry.
  - Pop occurs when fifo_valid & fifo_ready.
  - Push when not full: word written.
  - Push when full with no pop: word dropped, overflow_count += 1, saturating at 16'hFFFF.
  - Push and pop in the same cycle while full: both performed, no overflow.
  - Push and pop in the same cycle while empty: the word is written; fifo_valid rises the next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits with wrap-bit full/empty detection. Pointer wrap-around has no other effect.
- Reset values: fifo_valid=0, fifo_data=0, fifo_partial=0, overflow_count=0, busy=0. FIFO is empty, bit_cnt=0.
- Reset mid-packet: the partial word is discarded with no flush push. The next full packet after release is assembled correctly.
- fifo_data and fifo_partial hold their value while fifo_valid=1 and fifo_ready=0.

Decomposition:
- Package serial_rx_pkg holds:
  - a clog2 function;
  - CNT_W = clog2(PACKET_LENGTH+1);
  - the overflow counter width constant (16);
  - the entry layout: {partial, data}, width PACKET_LENGTH+1.
- One sub-module, rx_sync_fifo: show-ahead synchronous FIFO with parameters WIDTH and DEPTH and ports push/din/full/pop/dout/empty.
- The top level contains the synchronisers, edge detect, shifter/counter, flush logic and overflow counter.

Test Plan:
1. LANES=1, MSB_FIRST=1; 32 bits of 0xDEADBEEF MSB first with svalid high; fifo_ready=1. Expect one word 0xDEADBEEF with fifo_partial=0 and overflow_count=0.
2. LANES=4; 8 nibble beats A,5,A,5,1,2,3,4. Expect word 0xA5A51234 with partial=0. Then two back-to-back packets with svalid held high throughout. Expect two words in order.
3. LANES=1, MSB_FIRST=1; 27 bits all 1 followed by svalid falling. Expect word 0x07FFFFFF with partial=1 and busy low afterwards.
4. fifo_ready=0 with FIFO_DEPTH=4; send 6 packets 0x1..0x6. Expect overflow_count=2. Then set fifo_ready=1. Expect 0x1..0x4 popped in order, then fifo_valid=0.
5. MSB_FIRST=0, LANES=1; first bit 1 and 31 zeros. Expect word 0x00000001.
6. aresetn pulsed low after 16 bits of a packet. Expect no word, busy=0 and all outputs at reset values. Then a full packet 0x12345678. Expect exactly that word.
